// File: rtl/mul_rpt_add_ctrl_pkg.sv
// ============================================================================
// Module      : mul_rpt_add_ctrl_pkg
// Description : Shared state encoding and default sizing for the
//               repeated-addition multiplier controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_rpt_add_ctrl_pkg;

    localparam int unsigned c_cnt_w    = 16;
    localparam int unsigned c_max_iter = 65535;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_CHECK  = 3'd3,
        ST_ADD    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_iter_cnt.sv
// ============================================================================
// Module      : mul_iter_cnt
// Description : Saturating iteration counter with synchronous clear and a
//               terminal-count flag at MAX_ITER.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_iter_cnt
    import mul_rpt_add_ctrl_pkg::*;
#(
    parameter int CNT_W    = c_cnt_w,
    parameter int MAX_ITER = c_max_iter
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] c_term = CNT_W'(MAX_ITER);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == c_term);
    assign o_tc = w_tc;

    // Holds at the terminal value instead of wrapping back to zero.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_rpt_add_ctrl.sv
// ============================================================================
// Module      : mul_rpt_add_ctrl
// Description : Moore controller sequencing a repeated-addition multiplier
//               datapath, with an iteration watchdog for a stuck zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_rpt_add_ctrl
    import mul_rpt_add_ctrl_pkg::*;
#(
    parameter int CNT_W    = c_cnt_w,
    parameter int MAX_ITER = c_max_iter
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic eqz,
    output logic ldA,
    output logic ldB,
    output logic clrP,
    output logic ldP,
    output logic decB,
    output logic busy,
    output logic done,
    output logic err
);

    state_t r_state;
    state_t w_nxt;
    logic   w_tc;

    mul_iter_cnt #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == ST_LOAD_B),
        .i_en  (r_state == ST_ADD),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // eqz takes priority so B == MAX_ITER still completes without error.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_nxt = ST_LOAD_A;
            ST_LOAD_A: w_nxt = ST_LOAD_B;
            ST_LOAD_B: w_nxt = ST_CHECK;
            ST_CHECK: begin
                if (eqz) begin
                    w_nxt = ST_DONE;
                end else if (w_tc) begin
                    w_nxt = ST_ERR;
                end else begin
                    w_nxt = ST_ADD;
                end
            end
            ST_ADD:    w_nxt = ST_CHECK;
            ST_DONE:   w_nxt = ST_IDLE;
            ST_ERR:    w_nxt = ST_IDLE;
            default:   w_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ldA  = 1'b0;
        ldB  = 1'b0;
        clrP = 1'b0;
        ldP  = 1'b0;
        decB = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        busy = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD_A: ldA = 1'b1;
            ST_LOAD_B: begin
                ldB  = 1'b1;
                clrP = 1'b1;
            end
            ST_ADD: begin
                ldP  = 1'b1;
                decB = 1'b1;
            end
            ST_DONE:   done = 1'b1;
            ST_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_rpt_add_ctrl.sv
// ============================================================================
// Module      : tb_mul_rpt_add_ctrl
// Description : Scoreboard bench for mul_rpt_add_ctrl with a behavioural
//               A/B/P datapath and a B==0 comparator feeding eqz.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_rpt_add_ctrl;

    localparam int MAX_IT = 4;

    typedef struct {
        logic [31:0] p;
        logic        err;
        int          lat;
        int          nadd;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, eqz;
    logic ldA, ldB, clrP, ldP, decB, busy, done, err;

    logic [15:0] opA = '0, opB = '0, dpA = '0, dpB = '0;
    logic [31:0] dpP = '0;
    logic        frc = 1'b0;
    logic [15:0] bus;

    int   checks = 0, failures = 0;
    int   cyc = 0, ldA_cyc = 0, nadd = 0, n_done = 0;
    bit   inrun = 1'b0;
    logic rst_q = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    mul_rpt_add_ctrl #(.CNT_W(16), .MAX_ITER(MAX_IT)) dut (
        .clk(clk), .rst(rst), .start(start), .eqz(eqz),
        .ldA(ldA), .ldB(ldB), .clrP(clrP), .ldP(ldP), .decB(decB),
        .busy(busy), .done(done), .err(err)
    );

    // Datapath model: shared bus carries A during ldA, B otherwise.
    assign bus = ldA ? opA : opB;
    assign eqz = frc ? 1'b0 : (dpB == 16'd0);

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
        if (ldA) dpA <= bus;
        if (ldB) dpB <= bus;
        else if (decB) dpB <= dpB - 16'd1;
        if (clrP) dpP <= '0;
        else if (ldP) dpP <= dpP + {16'd0, dpA};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: n iterations of P += A, capped by the watchdog at MAX_IT.
    function automatic exp_t model(input int a, input int b, input bit f);
        exp_t e;
        e.err  = f || (b > MAX_IT);
        e.nadd = e.err ? MAX_IT : b;
        e.p    = 32'(a) * 32'(e.nadd);
        e.lat  = 2 * e.nadd + 4;
        return e;
    endfunction

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_q) inrun = 1'b0;
            chk("ctrl_excl",
                64'((ldP && (ldA || ldB || clrP)) || (ldA && ldB) || (ldP != decB) ||
                    (err && !done) || (done && (ldA || ldB || clrP || ldP))), 64'd0);
            chk("busy", 64'(busy), 64'(inrun || ldA));
            if (ldA) begin
                inrun   = 1'b1;
                ldA_cyc = cyc;
                nadd    = 0;
            end
            if (ldP) nadd++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("product", 64'(dpP), 64'(e.p));
                    chk("err_flag", 64'(err), 64'(e.err));
                    chk("latency", 64'(cyc - ldA_cyc + 1), 64'(e.lat));
                    chk("add_pulses", 64'(nadd), 64'(e.nadd));
                end
                inrun = 1'b0;
                n_done++;
            end
        end
    end

    task automatic wait_done(input int budget);
        int n0;
        n0 = n_done;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_done > n0) return;
        end
        chk("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic run(input int a, input int b, input bit f);
        @(negedge clk);
        opA = 16'(a);
        opB = 16'(b);
        frc = f;
        q.push_back(model(a, b, f));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300);
        frc = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({ldA, ldB, clrP, ldP, decB, busy, done, err}), 64'd0);
        rst = 1'b0;

        run(5, 3, 1'b0);
        run(7, 0, 1'b0);
        run(0, 4, 1'b0);
        run(3, 2, 1'b1);
        run(9, 5, 1'b0);

        // Re-pulse start while busy, then reset mid-operation.
        @(negedge clk);
        opA = 16'd5;
        opB = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrun_reset", 64'({ldA, ldB, clrP, ldP, decB, busy, done, err}), 64'd0);
        rst = 1'b0;
        run(5, 3, 1'b0);

        // Start held high: back-to-back runs.
        @(negedge clk);
        opA = 16'd2;
        opB = 16'd1;
        q.push_back(model(2, 1, 1'b0));
        q.push_back(model(2, 1, 1'b0));
        start = 1'b1;
        wait_done(100);
        @(negedge clk);
        #1;
        chk("restart_idle", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        chk("restart_ldA", 64'(ldA), 64'd1);
        start = 1'b0;
        wait_done(100);

        for (int i = 0; i < 10; i++) begin
            run(int'($urandom_range(0, 65535)), int'($urandom_range(0, 6)),
                ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
